// File: rtl/data_ram_ctrl.sv
// Parametrised single-port data memory with power-on clear sweep, registered
// read data, a read-valid strobe and out-of-range address detection.
module data_ram_ctrl #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              ready,
    output logic              read_valid,
    output logic              addr_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L  = DEPTH[ADDR_W:0];
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

    state_t           state, state_next;
    logic [IDX_W-1:0] clr_cnt;
    logic [IDX_W-1:0] idx;
    logic             addr_ok;
    logic             req;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Full-width unsigned compare so upper address bits never alias into the array.
    assign addr_ok = ({1'b0, addr} < DEPTH_L);
    assign idx     = addr[IDX_W-1:0];
    assign req     = write_en | read_en;
    assign ready   = (state == IDLE);

    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_cnt == LAST_IDX) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RST_STATE;
            clr_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (write_en && addr_ok) begin
            mem[idx] <= Data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Data_out   <= '0;
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
        end else begin
            read_valid <= 1'b0;
            addr_err   <= 1'b0;
            if (state == IDLE && req) begin
                if (!addr_ok) begin
                    Data_out <= '0;
                    addr_err <= 1'b1;
                end else if (write_en) begin
                    Data_out   <= Data_in;
                    read_valid <= read_en;
                end else begin
                    Data_out   <= mem[idx];
                    read_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// Directed bench for data_ram_ctrl (DEPTH=32, clear-on-reset enabled).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next.
module tb_data_ram_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 9;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst_n;
    logic              write_en;
    logic              read_en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] Data_in;
    logic [DATA_W-1:0] Data_out;
    logic              ready;
    logic              read_valid;
    logic              addr_err;

    int n_cmp;
    int n_err;
    int edges;

    data_ram_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH(DEPTH),
        .CLEAR_ON_RESET(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write_en(write_en),
        .read_en(read_en),
        .addr(addr),
        .Data_in(Data_in),
        .Data_out(Data_out),
        .ready(ready),
        .read_valid(read_valid),
        .addr_err(addr_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_req(input logic we, input logic re, input int a, input logic [DATA_W-1:0] d);
        write_en = we;
        read_en  = re;
        addr     = ADDR_W'(a);
        Data_in  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_req(1'b0, 1'b0, 0, '0);
    endtask

    task automatic expect_out(input string tag, input logic [DATA_W-1:0] d,
                              input logic rv, input logic ae);
        check({tag, ".data"}, 32'(Data_out), 32'(d));
        check({tag, ".rv"}, 32'(read_valid), 32'(rv));
        check({tag, ".err"}, 32'(addr_err), 32'(ae));
    endtask

    // Count rising edges until ready, flagging any pulse seen during the sweep.
    task automatic wait_ready(output int cnt);
        cnt = 0;
        while (cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
            if (read_valid !== 1'b0 || addr_err !== 1'b0) begin
                check("sweep_pulse", {30'd0, read_valid, addr_err}, 32'd0);
            end
            if (ready === 1'b1) break;
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        addr     = '0;
        Data_in  = '0;
        #12;
        check("rst.ready", 32'(ready), 32'd0);
        expect_out("rst", 16'h0000, 1'b0, 1'b0);

        // First sweep, then fill with garbage.
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready(edges);
        check("sweep1.edges", 32'(edges), 32'd32);
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b1, 1'b0, i, 16'hA500 ^ 16'(i));
        end
        do_req(1'b0, 1'b1, 7, '0);
        expect_out("garbage7", 16'hA507, 1'b1, 1'b0);

        // Asynchronous reset clears outputs mid-cycle.
        rst_n = 1'b0;
        #1;
        check("async.ready", 32'(ready), 32'd0);
        expect_out("async", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;

        // Release while hammering a write to addr 3: sweep must ignore it.
        write_en = 1'b1;
        addr     = ADDR_W'(3);
        Data_in  = 16'hFFFF;
        rst_n    = 1'b1;
        wait_ready(edges);
        check("sweep2.edges", 32'(edges), 32'd32);
        check("sweep2.ready", 32'(ready), 32'd1);

        // Every word reads back zero, back-to-back.
        for (int i = 0; i < DEPTH; i++) begin
            do_req(1'b0, 1'b1, i, '0);
            check($sformatf("clr%0d.data", i), 32'(Data_out), 32'd0);
            check($sformatf("clr%0d.rv", i), 32'(read_valid), 32'd1);
        end
        idle();
        check("idle.rv", 32'(read_valid), 32'd0);

        // Writes are write-first; back-to-back reads.
        do_req(1'b1, 1'b0, 1, 16'h0003);
        expect_out("wr1", 16'h0003, 1'b0, 1'b0);
        do_req(1'b1, 1'b0, 2, 16'h0032);
        expect_out("wr2", 16'h0032, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 1, '0);
        expect_out("rd1", 16'h0003, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 2, '0);
        expect_out("rd2", 16'h0032, 1'b1, 1'b0);
        idle();
        expect_out("hold", 16'h0032, 1'b0, 1'b0);

        // Simultaneous write and read.
        do_req(1'b1, 1'b1, 5, 16'hBEEF);
        expect_out("wr_rd5", 16'hBEEF, 1'b1, 1'b0);
        idle();
        do_req(1'b0, 1'b1, 5, '0);
        expect_out("rd5", 16'hBEEF, 1'b1, 1'b0);

        // Out of range, including addresses whose low bits alias valid words.
        do_req(1'b1, 1'b0, 32, 16'h1234);
        expect_out("oor_wr32", 16'h0000, 1'b0, 1'b1);
        do_req(1'b0, 1'b1, 40, '0);
        expect_out("oor_rd40", 16'h0000, 1'b0, 1'b1);
        do_req(1'b1, 1'b1, 257, 16'h5555);
        expect_out("oor_257", 16'h0000, 1'b0, 1'b1);
        do_req(1'b0, 1'b1, 511, '0);
        expect_out("oor_511", 16'h0000, 1'b0, 1'b1);
        idle();
        expect_out("oor_idle", 16'h0000, 1'b0, 1'b0);
        do_req(1'b0, 1'b1, 0, '0);
        expect_out("chk0", 16'h0000, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 1, '0);
        expect_out("chk1", 16'h0003, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 3, '0);
        expect_out("chk3", 16'h0000, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 5, '0);
        expect_out("chk5", 16'hBEEF, 1'b1, 1'b0);
        do_req(1'b0, 1'b1, 8, '0);
        expect_out("chk8", 16'h0000, 1'b1, 1'b0);

        // Reset in the middle of a sweep restarts it from word 0.
        idle();
        rst_n = 1'b0;
        #1;
        check("mid.rst_ready", 32'(ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check($sformatf("mid%0d.ready", i), 32'(ready), 32'd0);
        end
        rst_n = 1'b0;
        #1;
        check("mid.ready", 32'(ready), 32'd0);
        expect_out("mid", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_ready(edges);
        check("sweep3.edges", 32'(edges), 32'd32);
        do_req(1'b0, 1'b1, 5, '0);
        expect_out("post5", 16'h0000, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Parametrised single-port data memory for the simple processor datapath, replacing the fixed 32×16 data RAM. It adds configurable width and depth, a power-on clear sweep with a ready handshake, registered read data with a valid strobe, and out-of-range address detection. The block sits between the processor's load/store path and the data-memory address space.

## Interface
- DATA_W, 16, data word width in bits
- ADDR_W, 9, address bus width in bits
- DEPTH, 32, number of implemented words; must satisfy 1 ≤ DEPTH ≤ 2^ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero every word after reset before accepting requests; 0 = skip the sweep
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- write_en  in  1  write request, sampled on the rising edge
- read_en  in  1  read request, sampled on the rising edge
- addr  in  ADDR_W  word address
- Data_in  in  DATA_W  write data
- Data_out  out  DATA_W  registered read data
- ready  out  1  high when requests are accepted
- read_valid  out  1  one-cycle pulse: Data_out updated by an accepted read
- addr_err  out  1  one-cycle pulse: an accepted request addressed a word ≥ DEPTH

## Operation
- Two states: CLEAR and IDLE. Reset forces CLEAR when CLEAR_ON_RESET=1 and IDLE when it is 0. The clear counter resets to 0.
- CLEAR:
  - Each edge writes 0 to word clr_cnt and increments clr_cnt.
  - On the edge that writes word DEPTH-1, the block moves to IDLE.
  - ready=0 throughout. write_en and read_en are ignored: no memory change, no pulses.
- IDLE: ready=1. A request is accepted when its enable is high on an edge.
  - Write, addr < DEPTH: mem[addr] ← Data_in. Data_out ← Data_in (write-first, so the written value is visible). read_valid pulses only if read_en is also high.
  - Read only, addr < DEPTH: Data_out ← mem[addr], and read_valid pulses.
  - write_en and read_en together at the same address: one write. Data_out shows the new data and read_valid pulses.
  - addr ≥ DEPTH with either enable high: no memory change, Data_out ← 0, addr_err pulses, read_valid stays 0.
  - No request: Data_out holds its value and both pulses stay 0.
- Address comparison is unsigned over the full ADDR_W bits. There is no wrap-around and no aliasing of the upper bits.
- Reset asserted mid-sweep or mid-operation: the block returns to its reset state immediately. The sweep restarts from word 0 when reset is released. With CLEAR_ON_RESET=0, memory contents are not guaranteed after reset.

## Timing
- Reset values: Data_out=0, read_valid=0, addr_err=0, ready=0 if CLEAR_ON_RESET=1 and ready=1 if CLEAR_ON_RESET=0.
- Clear duration: exactly DEPTH rising edges after rst_n deasserts. ready rises after the DEPTH-th edge.
- Read latency: 1 cycle. With the request on edge N, Data_out and read_valid are valid after edge N. read_valid drops after edge N+1 unless another read is accepted then.
- Throughput: one request per cycle, with no bubbles between back-to-back reads or writes.
- addr_err has the same 1-cycle timing as read_valid.
- ready is a registered output with no combinational path from any input.
- Memory may be inferred as block RAM with a synchronous read. No output may depend combinationally on addr.

## Test plan
- Reset clear (DEPTH=32, CLEAR_ON_RESET=1): pre-load garbage, then pulse rst_n low → ready=0 for exactly 32 edges and then 1. Reading addresses 0..31 returns 0x0000 each, with read_valid one cycle after each request.
- Write/read: write 0x0003 to addr 1 and 0x0032 to addr 2, then read 1 and read 2 back-to-back → Data_out shows 0x0003 and then 0x0032 on consecutive cycles, with read_valid high for 2 cycles.
- Simultaneous write_en and read_en, addr 5, Data_in 0xBEEF → Data_out=0xBEEF and read_valid=1 on the next cycle. A later read of addr 5 returns 0xBEEF.
- Out of range: write 0x1234 to addr 32, then read addr 40 → addr_err pulses each time, Data_out=0, read_valid=0, and words 0..31 are unchanged.
- Requests during clear: hold write_en=1, addr 3, Data_in 0xFFFF through the sweep → no pulses, and a read of addr 3 after ready returns 0x0000.
- Reset mid-sweep: assert rst_n at sweep edge 10 → outputs return to reset values at once. After release, ready rises after 32 further edges.
